mcdf_arbiter: RTL and testbench
===============================

MCDF_ARBITER -- requirements
Module: mcdf_arbiter

Interface
REQ-001 SHALL have parameter: DW, 32, data word width of every slave channel and formatter output.
REQ-002 SHALL have ports, clock and reset first:
- clk_i  in  1  single clock; all state changes on rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- slvN_en_i (N=0,1,2)  in  1  channel enable from control register.
- slvN_prio_i  in  2  channel priority; 0 highest, 3 lowest.
- slvN_pkglen_i  in  3  packet length code.
- slvN_req_i  in  1  channel holds at least one complete packet.
- slvN_data_i  in  DW  head word of channel FIFO.
- slvN_ack_o  out  1  pops one word from channel FIFO.
- fmt_req_o  out  1  packet ready, requesting formatter.
- fmt_grant_i  in  1  formatter accepts the pending packet.
- fmt_ready_i  in  1  formatter accepts a data word this cycle.
- fmt_chid_o  out  2  channel id of current packet.
- fmt_len_o  out  6  word count of current packet.
- fmt_valid_o  out  1  fmt_data_o valid this cycle.
- fmt_data_o  out  DW  data word.
- fmt_start_o  out  1  first word of packet.
- fmt_end_o  out  1  last word of packet.

Function
REQ-003 SHALL implement FSM IDLE -> REQ -> SEND -> IDLE.
REQ-004 Eligible channel: slvN_en_i=1 and slvN_req_i=1.
REQ-005 IDLE: if any channel eligible, SHALL latch winner into fmt_chid_o and its length into fmt_len_o, go to REQ next cycle; otherwise stay in IDLE.
REQ-006 Winner: lowest slvN_prio_i value among eligible channels.
REQ-007 Priority tie: round-robin; search starts at (last granted id + 1) mod 3.
REQ-008 Length map: pkglen 0->4, 1->8, 2->16, 3..7->32 words.
REQ-009 REQ: fmt_req_o=1; on fmt_grant_i=1 SHALL go to SEND next cycle, fmt_req_o deasserted in that cycle.
REQ-010 REQ: slvN_req_i, slvN_en_i, prio and pkglen changes SHALL be ignored; the latched packet is committed.
REQ-011 SEND: word transfer occurs in a cycle with fmt_ready_i=1.
- slvN_ack_o=1 for the latched channel only.
- fmt_valid_o=1.
- fmt_data_o = slvN_data_i of the latched channel; combinational, zero latency.
REQ-012 SEND with fmt_ready_i=0: no ack, fmt_valid_o=0, word counter held (stall).
REQ-013 Word counter SHALL be 6 bits, cleared on entry to SEND, incremented per transfer.
REQ-014 fmt_start_o=1 on the transfer with counter=0.
REQ-015 fmt_end_o=1 on the transfer with counter=fmt_len_o-1.
REQ-016 After the end transfer, SHALL return to IDLE next cycle and update last-granted id to fmt_chid_o.
- Minimum gap between packets: one IDLE cycle.
REQ-017 Enable dropping during SEND SHALL NOT abort the packet; the full fmt_len_o words are transferred.
REQ-018 Outside SEND, all slvN_ack_o, fmt_valid_o, fmt_start_o, fmt_end_o SHALL be 0 and fmt_data_o SHALL be 0.
REQ-019 At most one slvN_ack_o SHALL be high in any cycle.

Reset
REQ-020 rst_i=1 at a rising edge: state IDLE, counter 0, fmt_chid_o=0, fmt_len_o=0, fmt_req_o=0, all strobes 0.
- Last-granted id = 2, so channel 0 wins the first tie.
REQ-021 Reset mid-packet SHALL abandon the packet with no further ack; channel FIFOs are not restored.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Single channel: ch1 en, req, pkglen=0, fmt_grant_i and fmt_ready_i tied 1.
  - fmt_req_o for 1 cycle, then 4 consecutive acks on slv1.
  - start on word 0, end on word 3, fmt_chid_o=1, fmt_len_o=4.
- Priority: ch0 prio 2, ch2 prio 1, both requesting -> ch2 packet first, then ch0.
- Round-robin: all prio 0, all always requesting, pkglen=0.
  - Grant order 0,1,2,0.
  - Each packet 4 words, one IDLE cycle between packets.
- Stall: pkglen=1, fmt_ready_i toggling 1,0 each cycle.
  - 8 acks over 16 cycles; counter holds during stalls; fmt_end_o on the 8th transfer.
- Disable/length edge: ch0 pkglen=7, en dropped after word 5 -> 32 words still transferred.
  - Separately: channel with en=0, req=1 is never granted.
- Reset mid-SEND at word 2 -> next cycle all outputs 0, state IDLE.
  - After reset, tie between ch1 and ch2 -> ch1 granted.

Source files
------------

// File: rtl/mcdf_arbiter.sv
// mcdf_arbiter: picks one of three slave channels by priority (round-robin on
// ties), requests the formatter, then streams the committed packet word by word.
module mcdf_arbiter #(
  parameter int DW = 32
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          slv0_en_i,
  input  logic [1:0]    slv0_prio_i,
  input  logic [2:0]    slv0_pkglen_i,
  input  logic          slv0_req_i,
  input  logic [DW-1:0] slv0_data_i,
  output logic          slv0_ack_o,
  input  logic          slv1_en_i,
  input  logic [1:0]    slv1_prio_i,
  input  logic [2:0]    slv1_pkglen_i,
  input  logic          slv1_req_i,
  input  logic [DW-1:0] slv1_data_i,
  output logic          slv1_ack_o,
  input  logic          slv2_en_i,
  input  logic [1:0]    slv2_prio_i,
  input  logic [2:0]    slv2_pkglen_i,
  input  logic          slv2_req_i,
  input  logic [DW-1:0] slv2_data_i,
  output logic          slv2_ack_o,
  output logic          fmt_req_o,
  input  logic          fmt_grant_i,
  input  logic          fmt_ready_i,
  output logic [1:0]    fmt_chid_o,
  output logic [5:0]    fmt_len_o,
  output logic          fmt_valid_o,
  output logic [DW-1:0] fmt_data_o,
  output logic          fmt_start_o,
  output logic          fmt_end_o
);

  typedef enum logic [1:0] {IDLE, REQ, SEND} state_t;

  state_t state, state_nxt;

  logic [1:0]    last_id;
  logic [5:0]    cnt;
  logic [3:0]    elig;
  logic [1:0]    prio_v   [4];
  logic [2:0]    pkglen_v [4];
  logic [DW-1:0] data_v   [4];

  logic       win_found;
  logic [1:0] win_id;
  logic [1:0] win_prio;
  logic [1:0] idx;
  logic       xfer;
  logic       last_word;

  // Slot 3 is an unused channel id; tying it off keeps 2-bit indexing in range.
  assign elig        = {1'b0, slv2_en_i & slv2_req_i, slv1_en_i & slv1_req_i, slv0_en_i & slv0_req_i};
  assign prio_v[0]   = slv0_prio_i;
  assign prio_v[1]   = slv1_prio_i;
  assign prio_v[2]   = slv2_prio_i;
  assign prio_v[3]   = 2'd3;
  assign pkglen_v[0] = slv0_pkglen_i;
  assign pkglen_v[1] = slv1_pkglen_i;
  assign pkglen_v[2] = slv2_pkglen_i;
  assign pkglen_v[3] = 3'd0;
  assign data_v[0]   = slv0_data_i;
  assign data_v[1]   = slv1_data_i;
  assign data_v[2]   = slv2_data_i;
  assign data_v[3]   = '0;

  function automatic logic [5:0] len_map(input logic [2:0] code);
    case (code)
      3'd0:    len_map = 6'd4;
      3'd1:    len_map = 6'd8;
      3'd2:    len_map = 6'd16;
      default: len_map = 6'd32;
    endcase
  endfunction

  // Scan channels in round-robin order from the one after the last grant; a
  // strictly lower priority replaces the candidate, so ties keep the earliest.
  always_comb begin
    win_found = 1'b0;
    win_id    = 2'd0;
    win_prio  = 2'd3;
    idx       = 2'd0;
    for (int k = 0; k < 3; k++) begin
      idx = 2'(({30'd0, last_id} + 32'(k) + 32'd1) % 32'd3);
      if (elig[idx] && (!win_found || (prio_v[idx] < win_prio))) begin
        win_found = 1'b1;
        win_id    = idx;
        win_prio  = prio_v[idx];
      end
    end
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode plus the per-cycle transfer qualifiers.
  always_comb begin
    state_nxt = state;
    xfer      = 1'b0;
    last_word = 1'b0;
    case (state)
      IDLE: if (win_found) state_nxt = REQ;
      REQ:  if (fmt_grant_i) state_nxt = SEND;
      SEND: begin
        if (fmt_ready_i) begin
          xfer = 1'b1;
          if (cnt == 6'(fmt_len_o - 6'd1)) begin
            last_word = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Packet bookkeeping: latch winner in IDLE, count words, remember last grant.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fmt_chid_o <= 2'd0;
      fmt_len_o  <= 6'd0;
      cnt        <= 6'd0;
      last_id    <= 2'd2;
    end else begin
      if (state == IDLE && win_found) begin
        fmt_chid_o <= win_id;
        fmt_len_o  <= len_map(pkglen_v[win_id]);
      end
      if (state == REQ && fmt_grant_i) cnt <= 6'd0;
      else if (xfer)                   cnt <= cnt + 6'd1;
      if (last_word) last_id <= fmt_chid_o;
    end
  end

  // Formatter-side strobes and the zero-latency data path from the latched channel.
  always_comb begin
    fmt_req_o   = (state == REQ);
    fmt_valid_o = xfer;
    fmt_start_o = xfer && (cnt == 6'd0);
    fmt_end_o   = last_word;
    fmt_data_o  = xfer ? data_v[fmt_chid_o] : '0;
    slv0_ack_o  = xfer && (fmt_chid_o == 2'd0);
    slv1_ack_o  = xfer && (fmt_chid_o == 2'd1);
    slv2_ack_o  = xfer && (fmt_chid_o == 2'd2);
  end

endmodule

// File: tb/tb_mcdf_arbiter.sv
// tb_mcdf_arbiter: directed plus random stimulus, transaction-level reference
// model feeding header and word queues, independent negedge monitor.
module tb_mcdf_arbiter;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          en     [3];
  logic [1:0]    prio   [3];
  logic [2:0]    pkglen [3];
  logic          req    [3];
  logic [DW-1:0] data   [3];
  logic          ack    [3];
  logic          fmt_grant, fmt_ready;
  logic          fmt_req, fmt_valid, fmt_start, fmt_end;
  logic [1:0]    fmt_chid;
  logic [5:0]    fmt_len;
  logic [DW-1:0] fmt_data;

  always #5 clk = ~clk;

  mcdf_arbiter #(.DW(DW)) dut (
    .clk_i(clk), .rst_i(rst),
    .slv0_en_i(en[0]), .slv0_prio_i(prio[0]), .slv0_pkglen_i(pkglen[0]),
    .slv0_req_i(req[0]), .slv0_data_i(data[0]), .slv0_ack_o(ack[0]),
    .slv1_en_i(en[1]), .slv1_prio_i(prio[1]), .slv1_pkglen_i(pkglen[1]),
    .slv1_req_i(req[1]), .slv1_data_i(data[1]), .slv1_ack_o(ack[1]),
    .slv2_en_i(en[2]), .slv2_prio_i(prio[2]), .slv2_pkglen_i(pkglen[2]),
    .slv2_req_i(req[2]), .slv2_data_i(data[2]), .slv2_ack_o(ack[2]),
    .fmt_req_o(fmt_req), .fmt_grant_i(fmt_grant), .fmt_ready_i(fmt_ready),
    .fmt_chid_o(fmt_chid), .fmt_len_o(fmt_len), .fmt_valid_o(fmt_valid),
    .fmt_data_o(fmt_data), .fmt_start_o(fmt_start), .fmt_end_o(fmt_end)
  );

  typedef struct {
    logic [1:0]    chid;
    logic [DW-1:0] data;
    logic          first;
    logic          last;
  } word_t;

  typedef struct {
    logic [1:0] chid;
    logic [5:0] len;
  } hdr_t;

  word_t wq[$];
  hdr_t  hq[$];

  int n_cmp  = 0;
  int n_fail = 0;
  bit mon_on = 1'b0;

  // Reference model: 0 = waiting for work, 1 = waiting for grant, 2 = sending.
  int m_phase = 0;
  int m_last  = 2;
  int m_chid  = 0;
  int m_len   = 0;
  int m_sent  = 0;
  int m_done  = 0;

  int ready_mode = 0;   // 0: always 1, 1: toggle, 2: random
  int grant_mode = 0;   // 0: always 1, 1: random

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic failNow(input string name);
    n_cmp++;
    n_fail++;
    $display("[TB] FAIL %s: condition not met at %0t", name, $time);
  endtask

  // One clock cycle: randomize data, predict this cycle's transfer, advance the model.
  task automatic applyStimulus();
    int   nphase = m_phase, nlast = m_last, nchid = m_chid, nlen = m_len, nsent = m_sent;
    bit   push_hdr = 1'b0;
    hdr_t h;
    int   minp, pick, id, code;
    for (int i = 0; i < 3; i++) data[i] = $urandom;
    if (ready_mode == 1)      fmt_ready = ~fmt_ready;
    else if (ready_mode == 2) fmt_ready = 1'($urandom_range(0, 1));
    else                      fmt_ready = 1'b1;
    fmt_grant = (grant_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;

    if (m_phase == 2 && fmt_ready) begin
      word_t w;
      w.chid  = 2'(m_chid);
      w.data  = data[m_chid];
      w.first = (m_sent == 0);
      w.last  = (m_sent == m_len - 1);
      wq.push_back(w);
    end

    if (rst) begin
      nphase = 0; nlast = 2; nchid = 0; nlen = 0; nsent = 0;
    end else if (m_phase == 0) begin
      minp = 4;
      pick = -1;
      for (int i = 0; i < 3; i++)
        if (en[i] && req[i] && int'(prio[i]) < minp) minp = int'(prio[i]);
      for (int k = 1; k <= 3; k++) begin
        id = (m_last + k) % 3;
        if (pick < 0 && en[id] && req[id] && int'(prio[id]) == minp) pick = id;
      end
      if (pick >= 0) begin
        code     = (pkglen[pick] > 3) ? 3 : int'(pkglen[pick]);
        nchid    = pick;
        nlen     = 4 << code;
        nphase   = 1;
        h.chid   = 2'(nchid);
        h.len    = 6'(nlen);
        push_hdr = 1'b1;
      end
    end else if (m_phase == 1) begin
      if (fmt_grant) begin
        nphase = 2;
        nsent  = 0;
      end
    end else if (fmt_ready) begin
      nsent = m_sent + 1;
      if (nsent == m_len) begin
        nphase = 0;
        nlast  = m_chid;
        m_done++;
      end
    end

    @(posedge clk);
    m_phase = nphase; m_last = nlast; m_chid = nchid; m_len = nlen; m_sent = nsent;
    if (push_hdr) hq.push_back(h);
    #1;
  endtask

  task automatic runCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus();
  endtask

  task automatic runPackets(input int n, input string name);
    int target = m_done + n;
    int budget = 2000;
    while (m_done < target && budget > 0) begin
      applyStimulus();
      budget--;
    end
    if (m_done < target) failNow(name);
  endtask

  task automatic runUntilSent(input int words, input string name);
    int budget = 500;
    while (!(m_phase == 2 && m_sent == words) && budget > 0) begin
      applyStimulus();
      budget--;
    end
    if (budget == 0) failNow(name);
  endtask

  task automatic clearChannels();
    for (int i = 0; i < 3; i++) begin
      en[i] = 1'b0; req[i] = 1'b0; prio[i] = 2'd0; pkglen[i] = 3'd0;
    end
  endtask

  task automatic applyReset();
    rst = 1'b1;
    applyStimulus();
    rst = 1'b0;
  endtask

  // Monitor: compare packet headers when a request appears and words when valid.
  always @(negedge clk) begin
    logic [2:0] acks;
    logic       prev_req;
    hdr_t       h;
    word_t      w;
    if (mon_on) begin
      acks = {ack[2], ack[1], ack[0]};
      checkOutput("ack_onehot", 64'($countones(acks) <= 1), 64'd1);
      if (fmt_req && !prev_req) begin
        if (hq.size() == 0) failNow("unexpected_req");
        else begin
          h = hq.pop_front();
          checkOutput("hdr_chid", 64'(fmt_chid), 64'(h.chid));
          checkOutput("hdr_len", 64'(fmt_len), 64'(h.len));
        end
      end
      prev_req = fmt_req;
      if (fmt_valid) begin
        if (wq.size() == 0) failNow("unexpected_word");
        else begin
          w = wq.pop_front();
          checkOutput("word_data", 64'(fmt_data), 64'(w.data));
          checkOutput("word_chid", 64'(fmt_chid), 64'(w.chid));
          checkOutput("word_start", 64'(fmt_start), 64'(w.first));
          checkOutput("word_end", 64'(fmt_end), 64'(w.last));
          checkOutput("word_ack", 64'(acks), 64'(3'b001 << w.chid));
        end
      end else begin
        checkOutput("idle_outputs", {27'd0, acks, fmt_start, fmt_end, fmt_data}, 64'd0);
      end
      if (wq.size() != 0) begin
        failNow("missed_word");
        wq.delete();
      end
    end else begin
      prev_req = 1'b0;
    end
  end

  initial begin
    clearChannels();
    for (int i = 0; i < 3; i++) data[i] = '0;
    fmt_grant = 1'b0;
    fmt_ready = 1'b0;
    rst = 1'b1;
    applyStimulus();
    applyStimulus();
    rst = 1'b0;
    checkOutput("reset_req", 64'(fmt_req), 64'd0);
    checkOutput("reset_chid", 64'(fmt_chid), 64'd0);
    checkOutput("reset_len", 64'(fmt_len), 64'd0);
    checkOutput("reset_valid", 64'(fmt_valid), 64'd0);
    mon_on = 1'b1;

    $display("[TB] single channel");
    en[1] = 1'b1; req[1] = 1'b1; pkglen[1] = 3'd0;
    runPackets(1, "single_timeout");
    req[1] = 1'b0;
    checkOutput("single_chid", 64'(fmt_chid), 64'd1);
    checkOutput("single_len", 64'(fmt_len), 64'd4);
    clearChannels();
    runCycles(3);

    $display("[TB] priority");
    en[0] = 1'b1; req[0] = 1'b1; prio[0] = 2'd2;
    en[2] = 1'b1; req[2] = 1'b1; prio[2] = 2'd1;
    runPackets(1, "prio_timeout_a");
    checkOutput("prio_first", 64'(fmt_chid), 64'd2);
    req[2] = 1'b0;
    runPackets(1, "prio_timeout_b");
    checkOutput("prio_second", 64'(fmt_chid), 64'd0);
    clearChannels();
    runCycles(3);

    $display("[TB] round robin");
    applyReset();
    for (int i = 0; i < 3; i++) begin
      en[i] = 1'b1; req[i] = 1'b1;
    end
    for (int p = 0; p < 4; p++) begin
      runPackets(1, "rr_timeout");
      checkOutput("rr_order", 64'(fmt_chid), 64'(p % 3));
    end
    clearChannels();
    runCycles(3);

    $display("[TB] stall");
    en[1] = 1'b1; req[1] = 1'b1; pkglen[1] = 3'd1;
    ready_mode = 1;
    runPackets(1, "stall_timeout");
    req[1] = 1'b0;
    checkOutput("stall_len", 64'(fmt_len), 64'd8);
    ready_mode = 0;
    clearChannels();
    runCycles(3);

    $display("[TB] enable drop and long packet");
    en[0] = 1'b1; req[0] = 1'b1; pkglen[0] = 3'd7;
    runUntilSent(5, "endrop_timeout");
    en[0] = 1'b0;
    runPackets(1, "long_timeout");
    checkOutput("long_len", 64'(fmt_len), 64'd32);
    clearChannels();
    en[2] = 1'b0; req[2] = 1'b1;
    runCycles(30);
    checkOutput("disabled_no_req", 64'(fmt_req), 64'd0);
    clearChannels();
    runCycles(2);

    $display("[TB] reset mid-packet");
    en[0] = 1'b1; req[0] = 1'b1; pkglen[0] = 3'd2;
    runUntilSent(2, "midrst_timeout");
    applyReset();
    clearChannels();
    checkOutput("midrst_req", 64'(fmt_req), 64'd0);
    checkOutput("midrst_chid", 64'(fmt_chid), 64'd0);
    checkOutput("midrst_len", 64'(fmt_len), 64'd0);
    checkOutput("midrst_strobes", {58'd0, ack[2], ack[1], ack[0], fmt_valid, fmt_start, fmt_end}, 64'd0);
    en[1] = 1'b1; req[1] = 1'b1; prio[1] = 2'd1;
    en[2] = 1'b1; req[2] = 1'b1; prio[2] = 2'd1;
    runPackets(1, "postrst_timeout");
    checkOutput("postrst_tie", 64'(fmt_chid), 64'd1);
    clearChannels();
    runCycles(3);

    $display("[TB] random traffic");
    ready_mode = 2;
    grant_mode = 1;
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < 3; i++) begin
        en[i]     = 1'($urandom_range(0, 3) != 0);
        req[i]    = 1'($urandom_range(0, 1));
        prio[i]   = 2'($urandom_range(0, 3));
        pkglen[i] = 3'($urandom_range(0, 7));
      end
      applyStimulus();
    end
    clearChannels();
    begin
      int budget = 500;
      while (m_phase != 0 && budget > 0) begin
        applyStimulus();
        budget--;
      end
      if (m_phase != 0) failNow("drain_timeout");
    end
    runCycles(3);
    checkOutput("hdr_queue_empty", 64'(hq.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
